imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Byte-stream boot loader. It writes a program image into the single-cycle RV32IM CPU's instruction memory and gates CPU execution.
- Holds the CPU in reset with PC writes disabled while loading.
- Assembles little-endian bytes into 32-bit instruction words, writes them sequentially into IMEM, then verifies an XOR checksum.
- Releases the CPU only on a verified image.
- Sits between the host/test stimulus and the CPU datapath's IMEM write port, PC-write enable and reset inputs.

Parameters:
INSTR_WIDTH, 32, instruction word width (fixed 4 bytes)
IMEM_DEPTH, 256, IMEM size in words; maximum legal word count
ADDR_WIDTH, 8, IMEM word-index width (log2 IMEM_DEPTH)

Ports:
BL_clk  input  1  clock, rising edge
BL_rst_n  input  1  asynchronous active-low reset
BL_start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
BL_in_valid  input  1  byte valid
BL_in_data  input  8  byte payload
BL_in_ready  output  1  loader can accept a byte
BL_IMemWrEn  output  1  IMEM write strobe, one cycle per word
BL_IMemWrAddr  output  ADDR_WIDTH  IMEM word index
BL_IMemWrData  output  INSTR_WIDTH  instruction word
BL_CPUHold  output  1  high = CPU held in reset
BL_PCWrite  output  1  drives CPU PC-write enable
BL_Busy  output  1  load in progress
BL_Done  output  1  image loaded and verified
BL_Error  output  1  load failed
BL_WordCount  output  16  words written in the current load

Behaviour:
- One clock BL_clk; BL_rst_n is asynchronous, active-low. All state is in flops reset by BL_rst_n.
- Reset values: state IDLE, BL_in_ready=0, BL_IMemWrEn=0, BL_IMemWrAddr=0, BL_IMemWrData=0, BL_CPUHold=1, BL_PCWrite=0, BL_Busy=0, BL_Done=0, BL_Error=0, BL_WordCount=0. All outputs are registered.
- Frame format:
  - count low byte, then count high byte (N, 16-bit);
  - then N*4 payload bytes, byte 0 of each word = bits[7:0];
  - then 1 checksum byte = XOR of all payload bytes.
- Handshake: a byte transfers on a rising edge with BL_in_valid & BL_in_ready. The sender holds data stable while valid & !ready. Throughput is one byte per cycle. A write strobe never stalls input.
- BL_in_ready=1 in HDR_LO, HDR_HI, PAYLOAD and CHECK; 0 in all other states.
- States and transitions:
  - IDLE / DONE / ERROR: on BL_start go to HDR_LO. Entering HDR_LO sets BL_CPUHold=1, BL_PCWrite=0, BL_Done=0, BL_Error=0, BL_WordCount=0, address=0, checksum=0, BL_Busy=1.
  - HDR_LO: on byte transfer go to HDR_HI.
  - HDR_HI: on byte transfer:
    - N>IMEM_DEPTH: go to ERROR (no writes).
    - N==0: go to CHECK.
    - otherwise: go to PAYLOAD.
    - N==IMEM_DEPTH is legal.
  - PAYLOAD: on the 4th byte of a word, BL_IMemWrEn=1 for exactly the next cycle, with the assembled word and the current address. Address and BL_WordCount increment with that strobe. After word N's 4th byte go to CHECK.
  - CHECK: on byte transfer:
    - equals running XOR: go to DONE, with BL_CPUHold=0, BL_PCWrite=1, BL_Done=1, BL_Busy=0 from the next cycle.
    - otherwise: go to ERROR, with BL_Error=1, BL_Busy=0, BL_CPUHold stays 1.
- BL_start is ignored in HDR_LO, HDR_HI, PAYLOAD and CHECK.
- Address never exceeds IMEM_DEPTH-1; there is no wrap because N is range-checked first.
- Reset mid-load: immediate return to reset values. IMEM words already written remain. A partially assembled word is discarded and not written.
- In ERROR the CPU stays held; recovery is by BL_start.

Decomposition:
- Shared header bl_defs.vh: state encodings (IDLE, HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERROR), frame field sizes, reset constants.
- Sub-module bl_word_assembler: 2-bit byte-lane counter, 32-bit shift/assembly register, XOR accumulator, word_ready pulse. Cleared on load start.
- Top level: FSM, address/count registers, output registers.

Test Plan:
- Reset -> every output at its reset value; BL_CPUHold=1, BL_PCWrite=0; BL_in_ready=0 until BL_start.
- Start, bytes 02 00 13 05 A0 00 93 05 B0 00 90, back-to-back:
  - writes addr0=0x00A00513, then addr1=0x00B00593, each strobe exactly one cycle;
  - BL_Done=1, BL_CPUHold=0, BL_PCWrite=1, BL_WordCount=2.
- Same frame with checksum 91 -> both writes occur; BL_Error=1, BL_Done=0, BL_CPUHold=1, BL_PCWrite=0.
- Header 01 01 (N=257) -> BL_Error=1 right after HDR_HI, zero write strobes, BL_in_ready=0.
- Same frame as the second scenario, with BL_in_valid gapped randomly and a BL_start pulse mid-payload -> identical writes and result; the start is ignored.
- Reset asserted after 5 payload bytes -> exactly one write seen (addr0); outputs return to reset values. A new BL_start plus the full second-scenario frame then succeeds.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the IMEM boot loader: FSM state encodings,
// frame field sizes and the values every output takes in reset.
package imem_boot_loader_pkg;

    // Frame field sizes
    localparam int unsigned BL_BYTE_WIDTH     = 8;
    localparam int unsigned BL_WORD_WIDTH     = 32;
    localparam int unsigned BL_BYTES_PER_WORD = 4;
    localparam int unsigned BL_COUNT_WIDTH    = 16;
    localparam int unsigned BL_LANE_WIDTH     = 2;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR_LO  = 3'd1;
    localparam logic [2:0] ST_HDR_HI  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERROR   = 3'd6;

    // Output values held while reset is asserted
    localparam logic RST_IN_READY = 1'b0;
    localparam logic RST_WR_EN    = 1'b0;
    localparam logic RST_CPU_HOLD = 1'b1;
    localparam logic RST_PC_WRITE = 1'b0;
    localparam logic RST_BUSY     = 1'b0;
    localparam logic RST_DONE     = 1'b0;
    localparam logic RST_ERROR    = 1'b0;

    // States in which the loader accepts bytes from the stream
    function automatic logic bl_accepts_bytes(input logic [2:0] state);
        return (state == ST_HDR_LO) || (state == ST_HDR_HI) ||
               (state == ST_PAYLOAD) || (state == ST_CHECK);
    endfunction

    // States from which BL_start launches a new load
    function automatic logic bl_can_start(input logic [2:0] state);
        return (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Byte-to-word assembler for the boot loader: tracks the byte lane of the
// current word, shifts payload bytes in little-endian order and keeps the
// running XOR of every payload byte. The completed word is presented
// combinationally together with the 4th byte so the parent can register
// the IMEM write strobe on the very same edge.
module bl_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_byte_en,
    input  logic [BL_BYTE_WIDTH-1:0] i_byte,
    output logic                     o_word_ready,
    output logic [BL_WORD_WIDTH-1:0] o_word,
    output logic [BL_BYTE_WIDTH-1:0] o_xor
);

    logic [BL_LANE_WIDTH-1:0] r_lane;
    logic [BL_WORD_WIDTH-1:0] r_shift;
    logic [BL_BYTE_WIDTH-1:0] r_xor;
    logic [BL_WORD_WIDTH-1:0] w_shift_nxt;

    // New bytes enter at the top so byte 0 ends up in bits [7:0]
    assign w_shift_nxt  = {i_byte, r_shift[BL_WORD_WIDTH-1:BL_BYTE_WIDTH]};
    assign o_word       = w_shift_nxt;
    assign o_word_ready = i_byte_en && (r_lane == BL_LANE_WIDTH'(BL_BYTES_PER_WORD - 1));
    assign o_xor        = r_xor;

    // Lane counter, shift register and checksum accumulator
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane  <= '0;
            r_shift <= '0;
            r_xor   <= '0;
        end else if (i_clear) begin
            r_lane  <= '0;
            r_shift <= '0;
            r_xor   <= '0;
        end else if (i_byte_en) begin
            r_lane  <= r_lane + 1'b1;
            r_shift <= w_shift_nxt;
            r_xor   <= r_xor ^ i_byte;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader. Receives a framed program image, writes it into
// instruction memory one word at a time, verifies the XOR checksum and only
// then releases the CPU from reset and enables its PC writes.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned IMEM_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH  = 8
) (
    input  logic                   BL_clk,
    input  logic                   BL_rst_n,
    input  logic                   BL_start,
    input  logic                   BL_in_valid,
    input  logic [7:0]             BL_in_data,
    output logic                   BL_in_ready,
    output logic                   BL_IMemWrEn,
    output logic [ADDR_WIDTH-1:0]  BL_IMemWrAddr,
    output logic [INSTR_WIDTH-1:0] BL_IMemWrData,
    output logic                   BL_CPUHold,
    output logic                   BL_PCWrite,
    output logic                   BL_Busy,
    output logic                   BL_Done,
    output logic                   BL_Error,
    output logic [15:0]            BL_WordCount
);

    localparam logic [BL_COUNT_WIDTH-1:0] LP_MAX_WORDS = BL_COUNT_WIDTH'(IMEM_DEPTH);

    logic [2:0]                r_state;
    logic [2:0]                w_state_nxt;
    logic [BL_BYTE_WIDTH-1:0]  r_cnt_lo;
    logic [BL_COUNT_WIDTH-1:0] r_num_words;
    logic [BL_COUNT_WIDTH-1:0] w_hdr_n;
    logic [BL_COUNT_WIDTH-1:0] w_count_inc;
    logic                      w_xfer;
    logic                      w_load_start;
    logic                      w_last_word;
    logic                      w_payload_en;
    logic                      w_word_ready;
    logic [BL_WORD_WIDTH-1:0]  w_word;
    logic [BL_BYTE_WIDTH-1:0]  w_xor;
    logic                      w_csum_ok;

    logic                      r_in_ready;
    logic                      r_wr_en;
    logic [ADDR_WIDTH-1:0]     r_wr_addr;
    logic [INSTR_WIDTH-1:0]    r_wr_data;
    logic                      r_cpu_hold;
    logic                      r_pc_write;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_error;
    logic [BL_COUNT_WIDTH-1:0] r_word_count;

    assign w_xfer       = BL_in_valid && r_in_ready;
    assign w_load_start = BL_start && bl_can_start(r_state);
    assign w_hdr_n      = {BL_in_data, r_cnt_lo};
    assign w_count_inc  = r_word_count + 1'b1;
    assign w_last_word  = (w_count_inc == r_num_words);
    assign w_payload_en = w_xfer && (r_state == ST_PAYLOAD);
    assign w_csum_ok    = (BL_in_data == w_xor);

    bl_word_assembler u_word_asm (
        .i_clk        (BL_clk),
        .i_rst_n      (BL_rst_n),
        .i_clear      (w_load_start),
        .i_byte_en    (w_payload_en),
        .i_byte       (BL_in_data),
        .o_word_ready (w_word_ready),
        .o_word       (w_word),
        .o_xor        (w_xor)
    );

    // Next-state decode for the load sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (w_load_start) w_state_nxt = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (w_xfer) w_state_nxt = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (w_xfer) begin
                    if (w_hdr_n > LP_MAX_WORDS) w_state_nxt = ST_ERROR;
                    else if (w_hdr_n == '0)     w_state_nxt = ST_CHECK;
                    else                        w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_word_ready && w_last_word) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_xfer) w_state_nxt = w_csum_ok ? ST_DONE : ST_ERROR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and byte-accept flag, which follows the next state so it is registered
    always_ff @(posedge BL_clk or negedge BL_rst_n) begin
        if (!BL_rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= RST_IN_READY;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= bl_accepts_bytes(w_state_nxt);
        end
    end

    // Capture of the 16-bit word count from the two header bytes
    always_ff @(posedge BL_clk or negedge BL_rst_n) begin
        if (!BL_rst_n) begin
            r_cnt_lo    <= '0;
            r_num_words <= '0;
        end else if (w_load_start) begin
            r_cnt_lo    <= '0;
            r_num_words <= '0;
        end else if (w_xfer && (r_state == ST_HDR_LO)) begin
            r_cnt_lo    <= BL_in_data;
        end else if (w_xfer && (r_state == ST_HDR_HI)) begin
            r_num_words <= w_hdr_n;
        end
    end

    // IMEM write port: one-cycle strobe on the edge after each 4th payload byte
    always_ff @(posedge BL_clk or negedge BL_rst_n) begin
        if (!BL_rst_n) begin
            r_wr_en      <= RST_WR_EN;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_load_start) begin
                r_wr_addr    <= '0;
                r_word_count <= '0;
            end else if (w_word_ready && (r_state == ST_PAYLOAD)) begin
                r_wr_en      <= 1'b1;
                r_wr_addr    <= r_word_count[ADDR_WIDTH-1:0];
                r_wr_data    <= INSTR_WIDTH'(w_word);
                r_word_count <= w_count_inc;
            end
        end
    end

    // CPU gating and status flags
    always_ff @(posedge BL_clk or negedge BL_rst_n) begin
        if (!BL_rst_n) begin
            r_cpu_hold <= RST_CPU_HOLD;
            r_pc_write <= RST_PC_WRITE;
            r_busy     <= RST_BUSY;
            r_done     <= RST_DONE;
            r_error    <= RST_ERROR;
        end else if (w_load_start) begin
            r_cpu_hold <= 1'b1;
            r_pc_write <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else if (w_state_nxt == ST_DONE && r_state == ST_CHECK) begin
            r_cpu_hold <= 1'b0;
            r_pc_write <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
        end else if (w_state_nxt == ST_ERROR && r_state != ST_ERROR) begin
            r_cpu_hold <= 1'b1;
            r_pc_write <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b1;
        end
    end

    assign BL_in_ready   = r_in_ready;
    assign BL_IMemWrEn   = r_wr_en;
    assign BL_IMemWrAddr = r_wr_addr;
    assign BL_IMemWrData = r_wr_data;
    assign BL_CPUHold    = r_cpu_hold;
    assign BL_PCWrite    = r_pc_write;
    assign BL_Busy       = r_busy;
    assign BL_Done       = r_done;
    assign BL_Error      = r_error;
    assign BL_WordCount  = r_word_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader. Expected IMEM writes are
// queued as frames are driven and popped by a monitor on each strobe.
module tb_imem_boot_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        BL_start;
    logic        BL_in_valid;
    logic [7:0]  BL_in_data;
    logic        BL_in_ready;
    logic        BL_IMemWrEn;
    logic [7:0]  BL_IMemWrAddr;
    logic [31:0] BL_IMemWrData;
    logic        BL_CPUHold;
    logic        BL_PCWrite;
    logic        BL_Busy;
    logic        BL_Done;
    logic        BL_Error;
    logic [15:0] BL_WordCount;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  wr_seen  = 0;
    bit  prev_en  = 1'b0;

    always #5 clk = ~clk;

    imem_boot_loader #(
        .INSTR_WIDTH (32),
        .IMEM_DEPTH  (256),
        .ADDR_WIDTH  (8)
    ) dut (
        .BL_clk        (clk),
        .BL_rst_n      (rst_n),
        .BL_start      (BL_start),
        .BL_in_valid   (BL_in_valid),
        .BL_in_data    (BL_in_data),
        .BL_in_ready   (BL_in_ready),
        .BL_IMemWrEn   (BL_IMemWrEn),
        .BL_IMemWrAddr (BL_IMemWrAddr),
        .BL_IMemWrData (BL_IMemWrData),
        .BL_CPUHold    (BL_CPUHold),
        .BL_PCWrite    (BL_PCWrite),
        .BL_Busy       (BL_Busy),
        .BL_Done       (BL_Done),
        .BL_Error      (BL_Error),
        .BL_WordCount  (BL_WordCount)
    );

    // Write monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (BL_IMemWrEn === 1'b1) begin
                wr_seen++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", BL_IMemWrAddr, BL_IMemWrData);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if ({BL_IMemWrAddr, BL_IMemWrData} !== {e.addr, e.data}) begin
                        n_errors++;
                        $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h", BL_IMemWrAddr, BL_IMemWrData, e.addr, e.data);
                    end
                end
                n_checks++;
                if (prev_en) begin
                    n_errors++;
                    $display("FAIL strobe_width: got strobe high 2 cycles, required 1");
                end
            end
            prev_en = (BL_IMemWrEn === 1'b1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        BL_start = 1'b1;
        @(negedge clk);
        BL_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        int cnt;
        @(negedge clk);
        if (gapped) begin
            BL_in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        BL_in_valid = 1'b1;
        BL_in_data  = b;
        cnt = 0;
        while (BL_in_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (BL_in_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got in_ready=%b, required 1 within 20 cycles", BL_in_ready);
        end
        @(posedge clk);
    endtask

    // Drives the first n_bytes of a frame and queues each word expected to be written
    task automatic send_frame(input bq_t f, input bit gapped, input bit mid_start, input int n_bytes);
        int nw;
        int p;
        nw = int'({f[1], f[0]});
        for (int i = 0; i < n_bytes; i++) begin
            if (mid_start && i == 7) begin
                @(negedge clk);
                BL_in_valid = 1'b0;
                BL_start    = 1'b1;
                @(negedge clk);
                BL_start    = 1'b0;
            end
            send_byte(f[i], gapped);
            p = i - 2;
            if (p >= 0 && p < 4 * nw && (p % 4) == 3 && nw <= 256)
                exp_q.push_back('{addr: 8'(p / 4), data: {f[i], f[i-1], f[i-2], f[i-3]}});
        end
        @(negedge clk);
        BL_in_valid = 1'b0;
    endtask

    function automatic bq_t frame_a(input logic [7:0] csum);
        bq_t f;
        f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        f.push_back(csum);
        return f;
    endfunction

    task automatic test_reset();
        n_checks++;
        if ({BL_in_ready, BL_IMemWrEn, BL_IMemWrAddr, BL_IMemWrData} !== 42'd0) begin
            n_errors++;
            $display("FAIL reset_wrport: got ready=%b en=%b addr=%h data=%h, required all 0", BL_in_ready, BL_IMemWrEn, BL_IMemWrAddr, BL_IMemWrData);
        end
        n_checks++;
        if ({BL_CPUHold, BL_PCWrite} !== 2'b10) begin
            n_errors++;
            $display("FAIL reset_cpu: got hold=%b pcwrite=%b, required hold=1 pcwrite=0", BL_CPUHold, BL_PCWrite);
        end
        n_checks++;
        if ({BL_Busy, BL_Done, BL_Error} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_status: got busy/done/error=%b, required 000", {BL_Busy, BL_Done, BL_Error});
        end
        n_checks++;
        if (BL_WordCount !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_count: got %0d, required 0", BL_WordCount);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (BL_in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL ready_before_start: got %b, required 0", BL_in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = wr_seen;
        pulse_start();
        n_checks++;
        if ({BL_Busy, BL_in_ready, BL_CPUHold, BL_Done} !== 4'b1110) begin
            n_errors++;
            $display("FAIL start_state: got busy/ready/hold/done=%b, required 1110", {BL_Busy, BL_in_ready, BL_CPUHold, BL_Done});
        end
        send_frame(frame_a(8'h90), 1'b0, 1'b0, 11);
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready} !== 6'b100100) begin
            n_errors++;
            $display("FAIL b2b_status: got done/err/hold/pcw/busy/ready=%b, required 100100", {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready});
        end
        n_checks++;
        if (BL_WordCount !== 16'd2) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d, required 2", BL_WordCount);
        end
        n_checks++;
        if (wr_seen - w0 != 2 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_writes: got %0d strobes (%0d pending), required 2 (0 pending)", wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        int w0;
        w0 = wr_seen;
        pulse_start();
        send_frame(frame_a(8'h91), 1'b0, 1'b0, 11);
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready} !== 6'b011000) begin
            n_errors++;
            $display("FAIL csum_status: got done/err/hold/pcw/busy/ready=%b, required 011000", {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready});
        end
        n_checks++;
        if (wr_seen - w0 != 2 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL csum_writes: got %0d strobes (%0d pending), required 2 (0 pending)", wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_oversize();
        int w0;
        bq_t f;
        w0 = wr_seen;
        f = '{8'h01, 8'h01};
        pulse_start();
        send_frame(f, 1'b0, 1'b0, 2);
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready} !== 6'b011000) begin
            n_errors++;
            $display("FAIL oversize_status: got done/err/hold/pcw/busy/ready=%b, required 011000", {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_seen != w0 || BL_in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL oversize_writes: got %0d strobes ready=%b, required 0 strobes ready=0", wr_seen - w0, BL_in_ready);
        end
    endtask

    task automatic test_gapped_mid_start();
        int w0;
        w0 = wr_seen;
        pulse_start();
        send_frame(frame_a(8'h90), 1'b1, 1'b1, 11);
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready} !== 6'b100100) begin
            n_errors++;
            $display("FAIL gapped_status: got done/err/hold/pcw/busy/ready=%b, required 100100", {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite, BL_Busy, BL_in_ready});
        end
        n_checks++;
        if (BL_WordCount !== 16'd2 || wr_seen - w0 != 2 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL gapped_writes: got count=%0d strobes=%0d pending=%0d, required 2/2/0", BL_WordCount, wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_empty_image();
        bq_t f;
        f = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_frame(f, 1'b0, 1'b0, 3);
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite} !== 4'b1001 || BL_WordCount !== 16'd0) begin
            n_errors++;
            $display("FAIL empty_image: got done/err/hold/pcw=%b count=%0d, required 1001 count=0", {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite}, BL_WordCount);
        end
    endtask

    task automatic test_full_depth();
        bq_t f;
        logic [7:0] x;
        logic [7:0] b;
        int w0;
        w0 = wr_seen;
        x = 8'h00;
        f = '{8'h00, 8'h01};
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom_range(0, 255));
            x = x ^ b;
            f.push_back(b);
        end
        f.push_back(x);
        pulse_start();
        send_frame(f, 1'b0, 1'b0, f.size());
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite} !== 4'b1001 || BL_WordCount !== 16'd256) begin
            n_errors++;
            $display("FAIL full_depth: got done/err/hold/pcw=%b count=%0d, required 1001 count=256", {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite}, BL_WordCount);
        end
        n_checks++;
        if (wr_seen - w0 != 256 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL full_depth_writes: got %0d strobes (%0d pending), required 256 (0 pending)", wr_seen - w0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int w0;
        w0 = wr_seen;
        pulse_start();
        send_frame(frame_a(8'h90), 1'b0, 1'b0, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({BL_in_ready, BL_IMemWrEn, BL_IMemWrAddr, BL_IMemWrData, BL_CPUHold, BL_PCWrite, BL_Busy, BL_Done, BL_Error, BL_WordCount}
            !== {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL midreset_outputs: got ready=%b en=%b addr=%h data=%h hold=%b pcw=%b busy=%b done=%b err=%b cnt=%0d, required reset values",
                     BL_in_ready, BL_IMemWrEn, BL_IMemWrAddr, BL_IMemWrData, BL_CPUHold, BL_PCWrite, BL_Busy, BL_Done, BL_Error, BL_WordCount);
        end
        n_checks++;
        if (wr_seen - w0 != 1 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL midreset_writes: got %0d strobes (%0d pending), required 1 (0 pending)", wr_seen - w0, exp_q.size());
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        w0 = wr_seen;
        pulse_start();
        send_frame(frame_a(8'h90), 1'b0, 1'b0, 11);
        n_checks++;
        if ({BL_Done, BL_Error, BL_CPUHold, BL_PCWrite} !== 4'b1001 || BL_WordCount !== 16'd2 || wr_seen - w0 != 2) begin
            n_errors++;
            $display("FAIL midreset_reload: got done/err/hold/pcw=%b count=%0d strobes=%0d, required 1001 count=2 strobes=2",
                     {BL_Done, BL_Error, BL_CPUHold, BL_PCWrite}, BL_WordCount, wr_seen - w0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        BL_start    = 1'b0;
        BL_in_valid = 1'b0;
        BL_in_data  = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_reset();
        test_back_to_back();
        test_bad_checksum();
        test_oversize();
        test_gapped_mid_start();
        test_empty_image();
        test_full_depth();
        test_reset_mid_load();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
